uart_sdram_cmd_ctrl: RTL

- Command sequencer between the UART byte FIFOs and the SDRAM controller request port.
- Pops command bytes from the RX FIFO and assembles read/write commands.
- Issues one SDRAM access per command and pushes response bytes into the TX FIFO.
- Serialises all host accesses to the SDRAM through a single outstanding request.

---
 rtl/uart_sdram_cmd_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_sdram_cmd_ctrl.sv
// Command sequencer: assembles 'W'/'R' host commands from the RX byte FIFO,
// issues one SDRAM access at a time and returns the response through the TX FIFO.
module uart_sdram_cmd_ctrl #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_stb,
    output logic              rx_ack,
    output logic [7:0]        tx_data,
    output logic              tx_stb,
    input  logic              tx_ack,
    output logic              req_stb,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ack,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_WAIT_RD = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    // +2 keeps the counter at least one bit wide even for TIMEOUT == 0
    localparam int         TW      = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    logic [2:0]        state_q,   state_d;
    logic [1:0]        cnt_q,     cnt_d;
    logic [TW-1:0]     tmo_q,     tmo_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [7:0]        rdlo_q,    rdlo_d;
    logic              pend_q,    pend_d;
    logic [7:0]        txd_q,     txd_d;

    logic rx_state;

    assign rx_state  = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_ack    = rx_stb & rx_state;
    assign tx_stb    = (state_q == S_RESP);
    assign tx_data   = txd_q;
    assign req_stb   = (state_q == S_REQ);
    assign req_we    = we_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdlo_d  = rdlo_q;
        pend_d  = pend_q;
        txd_d   = txd_q;

        case (state_q)
            S_IDLE: begin
                if (rx_ack) begin
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        we_d    = (rx_data == OP_WRITE);
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end else begin
                        txd_d   = RSP_ERR;
                        pend_d  = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (rx_ack) begin
                    addr_d = {addr_q[ADDR_W-9:0], rx_data};
                    if (cnt_q == 2'd2) begin
                        cnt_d   = '0;
                        state_d = we_q ? S_DATA : S_REQ;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    txd_d   = RSP_ERR;
                    pend_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DATA: begin
                if (rx_ack) begin
                    wdata_d = {wdata_q[DATA_W-9:0], rx_data};
                    if (cnt_q == 2'd1) begin
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    txd_d   = RSP_ERR;
                    pend_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_REQ: begin
                if (req_ack) begin
                    if (we_q) begin
                        txd_d   = RSP_OK;
                        pend_d  = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end
            end

            S_WAIT_RD: begin
                // D1 goes out first; D0 is parked until the TX FIFO takes D1
                if (rd_valid) begin
                    txd_d   = rd_data[DATA_W-1 -: 8];
                    rdlo_d  = rd_data[7:0];
                    pend_d  = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (tx_ack) begin
                    if (pend_q) begin
                        txd_d  = rdlo_q;
                        pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdlo_q  <= '0;
            pend_q  <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdlo_q  <= rdlo_d;
            pend_q  <= pend_d;
            txd_q   <= txd_d;
        end
    end

endmodule
